core_wb_buf: RTL and testbench

- Writeback buffer sitting directly upstream of the architectural register file (16 x 16-bit TOY registers).
- Collects in-order results from the EX/MEM lanes, queues them in a small in-order FIFO, and drains up to N_OUT writes per cycle onto the register-file write ports.
- Writes to R0 are discarded, because TOY R0 always reads 0.
- Optional bypass lookup returns the newest pending value of a register for operand read.

---
 rtl/core_wb_buf_if.sv | 34 +++
 rtl/core_wb_buf.sv | 146 ++++++++++++++
 tb/tb_core_wb_buf.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_wb_buf_if.sv
// Writeback-buffer bus bundle: the result lanes coming in from EX/MEM and the
// register-file write ports going out.
//   master : result producer + register-file side (drives lanes, observes writes)
//   slave  : the writeback buffer itself
// Signals:
//   in_valid_i  [N_IN]      per-lane result valid (lane 0 oldest)
//   in_addr_i   [N_IN*4]    per-lane destination register
//   in_data_i   [N_IN*16]   per-lane result data
//   in_ready_o              all lanes may be accepted this cycle
//   wr_en_o     [N_OUT]     register-file write enables (registered)
//   wr_addr_o   [N_OUT*4]   write addresses (registered)
//   wr_data_o   [N_OUT*16]  write data (registered)
interface core_wb_buf_if #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 2
);
  logic [N_IN-1:0]     in_valid_i;
  logic [N_IN*4-1:0]   in_addr_i;
  logic [N_IN*16-1:0]  in_data_i;
  logic                in_ready_o;
  logic [N_OUT-1:0]    wr_en_o;
  logic [N_OUT*4-1:0]  wr_addr_o;
  logic [N_OUT*16-1:0] wr_data_o;

  modport master (
    output in_valid_i, in_addr_i, in_data_i,
    input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  in_valid_i, in_addr_i, in_data_i,
    output in_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/core_wb_buf.sv
// Writeback buffer in front of the 16 x 16-bit register file. Accepts up to
// N_IN in-order results per cycle, drops writes to R0, queues the rest in an
// in-order FIFO and drains up to N_OUT per cycle onto registered write ports
// (oldest on port 0).
// Optional feature macro: CORE_WB_BYPASS_EN enables the combinational bypass
// lookup returning the newest pending value per query; otherwise the bypass
// outputs are tied to zero.
// Ports:
//   clk_i, arst_ni   clock, asynchronous active-low reset
//   bus (slave)      result lanes in, register-file write ports out
//   stall_i          suppress draining this cycle
//   count_o          FIFO occupancy
//   empty_o          FIFO empty and no write port enabled
//   byp_addr_i       bypass query addresses (N_BYP x 4)
//   byp_hit_o        pending write found per query
//   byp_data_o       newest pending data per query (N_BYP x 16)
module core_wb_buf #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned N_BYP = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  core_wb_buf_if.slave              bus,
  input  logic                      stall_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o,
  input  logic [N_BYP*4-1:0]        byp_addr_i,
  output logic [N_BYP-1:0]          byp_hit_o,
  output logic [N_BYP*16-1:0]       byp_data_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [3:0]    mem_addr_q [DEPTH];
  logic [15:0]   mem_data_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [3:0]    push_addr [N_IN];
  logic [15:0]   push_data [N_IN];
  logic [CW-1:0] push_n, pop_n;
  logic          ready;

  // Ready depends only on registered occupancy.
  assign ready          = (CW'(DEPTH) - count_q) >= CW'(N_IN);
  assign bus.in_ready_o = ready;
  assign count_o        = count_q;
  assign empty_o        = (count_q == '0) && (bus.wr_en_o == '0);

  // Compact valid non-R0 lanes into consecutive push slots, lane order kept.
  always_comb begin
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      push_addr[k] = '0;
      push_data[k] = '0;
    end
    if (ready) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (bus.in_valid_i[i] && (bus.in_addr_i[i*4 +: 4] != 4'd0)) begin
          for (int unsigned k = 0; k < N_IN; k++) begin
            if (k == n) begin
              push_addr[k] = bus.in_addr_i[i*4 +: 4];
              push_data[k] = bus.in_data_i[i*16 +: 16];
            end
          end
          n = n + 1;
        end
      end
    end
    push_n = CW'(n);
  end

  // Drain count uses pre-push occupancy, so fresh entries never pass through.
  assign pop_n = stall_i ? '0 : ((count_q < CW'(N_OUT)) ? count_q : CW'(N_OUT));

  // FIFO storage; slots written here are never the ones popped this cycle.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (CW'(k) < push_n) begin
        mem_addr_q[tail_q + AW'(k)] <= push_addr[k];
        mem_data_q[tail_q + AW'(k)] <= push_data[k];
      end
    end
  end

  // Pointers, occupancy and registered write ports.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      bus.wr_en_o   <= '0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
    end else begin
      tail_q  <= tail_q + AW'(push_n);
      head_q  <= head_q + AW'(pop_n);
      count_q <= count_q + push_n - pop_n;
      for (int unsigned o = 0; o < N_OUT; o++) begin
        if (CW'(o) < pop_n) begin
          bus.wr_en_o[o]            <= 1'b1;
          bus.wr_addr_o[o*4 +: 4]   <= mem_addr_q[head_q + AW'(o)];
          bus.wr_data_o[o*16 +: 16] <= mem_data_q[head_q + AW'(o)];
        end else begin
          bus.wr_en_o[o] <= 1'b0;
        end
      end
    end
  end

`ifdef CORE_WB_BYPASS_EN
  // Later matches overwrite earlier ones: write ports low->high, then FIFO
  // oldest->youngest, so the youngest pending value wins.
  always_comb begin
    logic [3:0] q;
    byp_hit_o  = '0;
    byp_data_o = '0;
    q          = '0;
    for (int unsigned j = 0; j < N_BYP; j++) begin
      q = byp_addr_i[j*4 +: 4];
      if (q != 4'd0) begin
        for (int unsigned o = 0; o < N_OUT; o++) begin
          if (bus.wr_en_o[o] && (bus.wr_addr_o[o*4 +: 4] == q)) begin
            byp_hit_o[j]            = 1'b1;
            byp_data_o[j*16 +: 16]  = bus.wr_data_o[o*16 +: 16];
          end
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if ((CW'(k) < count_q) && (mem_addr_q[head_q + AW'(k)] == q)) begin
            byp_hit_o[j]            = 1'b1;
            byp_data_o[j*16 +: 16]  = mem_data_q[head_q + AW'(k)];
          end
        end
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^byp_addr_i;
  assign byp_hit_o  = '0;
  assign byp_data_o = '0;
`endif
endmodule

// File: tb/tb_core_wb_buf.sv
// Scoreboard bench for core_wb_buf: a queue-level reference model predicts
// occupancy, drain width, write order and bypass results; a negedge monitor
// compares the DUT against it.
module tb_core_wb_buf;
  localparam int unsigned N_IN  = 2;
  localparam int unsigned N_OUT = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned N_BYP = 4;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic                 stall = 1'b0;
  logic [N_BYP*4-1:0]   byp_addr = '0;
  logic [N_BYP-1:0]     hit;
  logic [N_BYP*16-1:0]  bdata;
  logic [3:0]           count;
  logic                 empty;

  core_wb_buf_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  core_wb_buf #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .N_BYP(N_BYP)) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .bus        (bus),
    .stall_i    (stall),
    .count_o    (count),
    .empty_o    (empty),
    .byp_addr_i (byp_addr),
    .byp_hit_o  (hit),
    .byp_data_o (bdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         m_fifo[$];   // pending entries, oldest first
  wr_t         sb[$];       // writes expected on the ports, in order
  wr_t         m_wr[N_OUT]; // entries presented on the ports this cycle
  int unsigned m_p = 0;     // number of enabled ports this cycle
  logic [15:0] rf[16];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Newest pending value: FIFO youngest->oldest, then enabled ports high->low.
  function automatic void byp_ref(input logic [3:0] q, output logic h, output logic [15:0] d);
    h = 1'b0;
    d = '0;
    if (q != 4'd0) begin
      for (int i = m_fifo.size() - 1; i >= 0 && !h; i--)
        if (m_fifo[i].a == q) begin h = 1'b1; d = m_fifo[i].d; end
      for (int o = int'(m_p) - 1; o >= 0 && !h; o--)
        if (m_wr[o].a == q) begin h = 1'b1; d = m_wr[o].d; end
    end
`ifndef CORE_WB_BYPASS_EN
    h = 1'b0;
    d = '0;
`endif
  endfunction

  // Reference model: one step per clock edge.
  always @(posedge clk) begin
    int  sz;
    int  p;
    bit  rdy;
    wr_t e;
    if (arst_n) begin
      sz  = m_fifo.size();
      rdy = (int'(DEPTH) - sz) >= int'(N_IN);
      p   = stall ? 0 : ((sz < int'(N_OUT)) ? sz : int'(N_OUT));
      m_p = p;
      for (int i = 0; i < p; i++) m_wr[i] = m_fifo.pop_front();
      if (rdy) begin
        for (int i = 0; i < int'(N_IN); i++) begin
          if (bus.in_valid_i[i] && bus.in_addr_i[i*4 +: 4] != 4'd0) begin
            e.a = bus.in_addr_i[i*4 +: 4];
            e.d = bus.in_data_i[i*16 +: 16];
            m_fifo.push_back(e);
            sb.push_back(e);
          end
        end
      end
    end
  end

  always @(negedge arst_n) begin
    m_fifo.delete();
    sb.delete();
    m_p = 0;
  end

  // Monitor.
  always @(negedge clk) begin
    int          sz;
    logic [3:0]  a;
    logic [15:0] d;
    logic        eh;
    logic [15:0] ed;
    wr_t         e;
    if (!arst_n) begin
      chk("rst_wr_en", 32'(bus.wr_en_o), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
    end else begin
      sz = m_fifo.size();
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(bus.in_ready_o), 32'((int'(DEPTH) - sz) >= int'(N_IN)));
      chk("wr_en", 32'(bus.wr_en_o), 32'((1 << m_p) - 1));
      chk("empty", 32'(empty), 32'(sz == 0 && m_p == 0));
      for (int o = 0; o < int'(N_OUT); o++) begin
        if (bus.wr_en_o[o]) begin
          a = bus.wr_addr_o[o*4 +: 4];
          d = bus.wr_data_o[o*16 +: 16];
          chk("wr_addr_not_r0", 32'(a != 4'd0), 1);
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL stale_write: port %0d got R%0d=0x%0h expected no write at %0t", o, a, d, $time);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(a), 32'(e.a));
            chk("wr_data", 32'(d), 32'(e.d));
          end
          rf[a] = d;
        end
      end
      for (int j = 0; j < int'(N_BYP); j++) begin
        byp_ref(byp_addr[j*4 +: 4], eh, ed);
        chk("byp_hit", 32'(hit[j]), 32'(eh));
        chk("byp_data", 32'(bdata[j*16 +: 16]), 32'(ed));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] v, input logic [3:0] a0, input logic [15:0] d0,
                           input logic [3:0] a1, input logic [15:0] d1);
    bus.in_valid_i = v;
    bus.in_addr_i  = {a1, a0};
    bus.in_data_i  = {d1, d0};
  endtask

  // Present lanes and hold them until accepted (bounded).
  task automatic offer(input logic [1:0] v, input logic [3:0] a0, input logic [15:0] d0,
                       input logic [3:0] a1, input logic [15:0] d1);
    bit took;
    took = 1'b0;
    set_lanes(v, a0, d0, a1, d1);
    for (int c = 0; c < 50 && !took; c++) begin
      took = bus.in_ready_o;
      step();
    end
    if (!took) begin
      n_chk++;
      $display("FAIL offer_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
    set_lanes(2'b00, 4'd0, 16'd0, 4'd0, 16'd0);
  endtask

  task automatic offer_rand_pair();
    offer(2'b11, 4'($urandom_range(1, 15)), 16'($urandom),
                 4'($urandom_range(1, 15)), 16'($urandom));
  endtask

  task automatic drain();
    stall = 1'b0;
    for (int c = 0; c < 40 && !empty; c++) step();
    chk("drain_empty", 32'(empty), 1);
  endtask

  initial begin
    logic [1:0]  v;
    logic [3:0]  a0, a1;
    logic [15:0] d0, d1;
    bit          took;

    for (int i = 0; i < 16; i++) rf[i] = '0;
    set_lanes(2'b00, 4'd0, 16'd0, 4'd0, 16'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    step();

    // Single lane latency.
    offer(2'b01, 4'd3, 16'h1234, 4'd0, 16'd0);
    chk("tp1_count", 32'(count), 1);
    step();
    chk("tp1_wr_en", 32'(bus.wr_en_o), 1);
    chk("tp1_addr", 32'(bus.wr_addr_o[3:0]), 3);
    chk("tp1_data", 32'(bus.wr_data_o[15:0]), 32'h1234);
    step();
    chk("tp1_empty", 32'(empty), 1);

    // R0 lane dropped.
    offer(2'b11, 4'd0, 16'hFFFF, 4'd5, 16'h00AA);
    chk("r0_count", 32'(count), 1);
    step();
    chk("r0_addr", 32'(bus.wr_addr_o[3:0]), 5);
    step();

    // Same-address pair drains together, higher port wins.
    offer(2'b11, 4'd7, 16'h0001, 4'd7, 16'h0002);
    step();
    chk("r7_wr_en", 32'(bus.wr_en_o), 3);
    chk("r7_p0", 32'(bus.wr_data_o[15:0]), 32'h0001);
    chk("r7_p1", 32'(bus.wr_data_o[31:16]), 32'h0002);
    step();
    chk("rf_r7", 32'(rf[7]), 32'h0002);
    chk("rf_r5", 32'(rf[5]), 32'h00AA);
    chk("rf_r3", 32'(rf[3]), 32'h1234);
    chk("rf_r0", 32'(rf[0]), 0);

    // Fill under stall until not ready, then release.
    stall = 1'b1;
    repeat (3) offer_rand_pair();
    chk("full_count6", 32'(count), 6);
    offer_rand_pair();
    chk("full_count8", 32'(count), 8);
    chk("full_ready", 32'(bus.in_ready_o), 0);
    set_lanes(2'b11, 4'd9, 16'hBEEF, 4'd10, 16'hCAFE);
    step();
    step();
    stall = 1'b0;
    offer(2'b11, 4'd9, 16'hBEEF, 4'd10, 16'hCAFE);
    drain();

    // Bypass: two pending writes to R4.
    stall = 1'b1;
    offer(2'b01, 4'd4, 16'h0011, 4'd0, 16'd0);
    offer(2'b01, 4'd4, 16'h0022, 4'd0, 16'd0);
    byp_addr = {4'd0, 4'd4, 4'd9, 4'd4};
    @(negedge clk);
`ifdef CORE_WB_BYPASS_EN
    chk("byp_r4_hit", 32'(hit[0]), 1);
    chk("byp_r4_data", 32'(bdata[15:0]), 32'h0022);
`else
    chk("byp_r4_hit", 32'(hit[0]), 0);
    chk("byp_r4_data", 32'(bdata[15:0]), 0);
`endif
    chk("byp_r9_hit", 32'(hit[1]), 0);
    chk("byp_r0_hit", 32'(hit[3]), 0);
    drain();

    // Randomized traffic; lanes held while not ready.
    took = 1'b1;
    v = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 600; c++) begin
      if (took) begin
        v  = 2'($urandom);
        a0 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
        a1 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
        d0 = 16'($urandom);
        d1 = 16'($urandom);
      end
      set_lanes(v, a0, d0, a1, d1);
      stall    = ($urandom_range(0, 9) < 3);
      byp_addr = 16'($urandom);
      took     = bus.in_ready_o;
      step();
    end
    set_lanes(2'b00, 4'd0, 16'd0, 4'd0, 16'd0);
    drain();

    // Reset mid-operation with count=5 and both ports writing.
    stall = 1'b1;
    repeat (3) offer_rand_pair();
    stall = 1'b0;
    offer(2'b01, 4'd6, 16'h5A5A, 4'd0, 16'd0);
    chk("prerst_count", 32'(count), 5);
    chk("prerst_wr_en", 32'(bus.wr_en_o), 3);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(bus.wr_en_o), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    step();
    @(negedge clk);
    arst_n = 1'b1;
    repeat (10) step();
    chk("postrst_count", 32'(count), 0);
    chk("postrst_wr_en", 32'(bus.wr_en_o), 0);
    chk("sb_all_retired", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
